// File: rtl/wb_conbus_rr_if.sv
// Bus bundle for the round-robin Wishbone interconnect. The conbus itself uses
// modport master; the attached masters/slaves (or a bench) use modport slave.
interface wb_conbus_rr_if #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 7
);
    logic [N_MASTERS*32-1:0] m_adr_i;
    logic [N_MASTERS*32-1:0] m_dat_i;
    logic [32*N_MASTERS-1:0] m_dat_o;
    logic [N_MASTERS*4-1:0]  m_sel_i;
    logic [N_MASTERS-1:0]    m_we_i;
    logic [N_MASTERS-1:0]    m_cyc_i;
    logic [N_MASTERS-1:0]    m_stb_i;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic [N_MASTERS-1:0]    m_err_o;
    logic [N_SLAVES*32-1:0]  s_adr_o;
    logic [N_SLAVES*32-1:0]  s_dat_o;
    logic [N_SLAVES*32-1:0]  s_dat_i;
    logic [N_SLAVES*4-1:0]   s_sel_o;
    logic [N_SLAVES-1:0]     s_we_o;
    logic [N_SLAVES-1:0]     s_cyc_o;
    logic [N_SLAVES-1:0]     s_stb_o;
    logic [N_SLAVES-1:0]     s_ack_i;

    modport master (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

    modport slave (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wb_conbus_rr.sv
// Shared-path Wishbone classic interconnect, N masters to M slaves, round-robin
// arbitration, address-MSB slave decode, error termination on unmapped or stalled accesses.
module wb_conbus_rr #(
    parameter int                             N_MASTERS  = 2,
    parameter int                             N_SLAVES   = 7,
    parameter int                             S_ADDR_W   = 4,
    parameter logic [N_SLAVES*S_ADDR_W-1:0]   S_ADDR_MAP = {4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
    parameter int                             TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_conbus_rr_if.master       bus,
    output logic [N_MASTERS-1:0] gnt_o
);

    localparam int         MIDX_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int         SIDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] BUSY     = 1'b1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [0:0]           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [MIDX_W-1:0]    gidx_q, gidx_d;
    logic [MIDX_W-1:0]    ptr_q, ptr_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 uerr_q, uerr_d;

    logic                 busy, gcyc, gstb, gwe;
    logic [31:0]          gadr, gdat, rdata;
    logic [3:0]           gsel;
    logic [N_SLAVES-1:0]  hit;
    logic                 mapped;
    logic [SIDX_W-1:0]    sidx;
    logic                 sack, tmo_err, err;
    logic                 found;
    logic [MIDX_W-1:0]    cand;

    always_comb begin
        busy = (state_q == BUSY);
        gcyc = busy & bus.m_cyc_i[gidx_q];
        gstb = gcyc & bus.m_stb_i[gidx_q];
        gwe  = bus.m_we_i[gidx_q];
        gadr = bus.m_adr_i[32*gidx_q +: 32];
        gdat = bus.m_dat_i[32*gidx_q +: 32];
        gsel = bus.m_sel_i[4*gidx_q +: 4];
    end

    always_comb begin
        hit    = '0;
        mapped = 1'b0;
        sidx   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            hit[k] = (gadr[31 -: S_ADDR_W] == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]);
            if (hit[k] && !mapped) begin
                mapped = 1'b1;
                sidx   = SIDX_W'(k);
            end
        end
    end

    // A stalled slave is cut off in the same cycle the error fires, so any late ack is dropped.
    always_comb begin
        sack    = gstb & mapped & bus.s_ack_i[sidx];
        tmo_err = (TIMEOUT != 0) && gstb && mapped && (tmo_q == TMO_LAST);
        err     = uerr_q | tmo_err;
        rdata   = mapped ? bus.s_dat_i[32*sidx +: 32] : 32'h0;
    end

    always_comb begin
        bus.s_adr_o = {N_SLAVES{gadr}};
        bus.s_dat_o = {N_SLAVES{gdat}};
        bus.s_sel_o = {N_SLAVES{gsel}};
        bus.s_we_o  = {N_SLAVES{gwe}};
        bus.s_cyc_o = {N_SLAVES{gcyc}} & hit;
        bus.s_stb_o = {N_SLAVES{gstb & ~tmo_err}} & hit;
        bus.m_dat_o = {N_MASTERS{rdata}};
        bus.m_ack_o = gnt_q & {N_MASTERS{sack & ~err}};
        bus.m_err_o = gnt_q & {N_MASTERS{err & gcyc}};
        gnt_o       = gnt_q;
    end

    // Arbitration: scan from the pointer with wrap; the burst keeps the bus until cyc drops.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand    = '0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < N_MASTERS; i++) begin
                    cand = MIDX_W'((int'(ptr_q) + i) % N_MASTERS);
                    if (!found && bus.m_cyc_i[cand]) begin
                        found  = 1'b1;
                        gidx_d = cand;
                        gnt_d  = N_MASTERS'(1) << cand;
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!gcyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (gidx_q == MIDX_W'(N_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        uerr_d = gstb & ~mapped & ~uerr_q;
        tmo_d  = '0;
        if ((TIMEOUT != 0) && gstb && mapped && !sack && !err) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
            uerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            uerr_q  <= uerr_d;
        end
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed-plus-random bench for wb_conbus_rr: grant order, decode, data path,
// unmapped and timeout error termination, async reset mid-transfer.
module tb_wb_conbus_rr;

    localparam int NM  = 2;
    localparam int NS  = 7;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NM-1:0] gnt;
    int            nAsserts = 0;
    int            nFails = 0;
    int            rrPtr = 0;
    int            slaveBase[NS] = '{0, 2, 3, 4, 5, 6, 7};

    wb_conbus_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS)) bus ();

    wb_conbus_rr #(
        .N_MASTERS (NM),
        .N_SLAVES  (NS),
        .S_ADDR_W  (4),
        .S_ADDR_MAP({4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0}),
        .TIMEOUT   (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    function automatic int decodeSlave(input logic [31:0] adr);
        for (int k = 0; k < NS; k++) begin
            if (int'(adr[31:28]) == slaveBase[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] randAddr(input int k);
        logic [31:0] r;
        r = $urandom();
        return {4'(slaveBase[k]), r[27:2], 2'b00};
    endfunction

    function automatic int pickGrant(input logic [NM-1:0] req);
        for (int i = 0; i < NM; i++) begin
            if (req[(rrPtr + i) % NM]) return (rrPtr + i) % NM;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int j, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat);
        bus.m_cyc_i[j]         = cyc;
        bus.m_stb_i[j]         = stb;
        bus.m_we_i[j]          = we;
        bus.m_adr_i[32*j +: 32] = adr;
        bus.m_dat_i[32*j +: 32] = dat;
        bus.m_sel_i[4*j +: 4]   = 4'hF;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rrPtr = 0;
    endtask

    initial begin : main
        logic [31:0] adr, rdata, wdata;
        int          slv, g;

        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
        bus.m_we_i  = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
        bus.s_ack_i = '0;
        for (int k = 0; k < NS; k++) bus.s_dat_i[32*k +: 32] = $urandom();

        // Reset state
        tick();
        #1;
        checkOutput("rst_gnt", 64'(gnt), 64'h0);
        checkOutput("rst_scyc", 64'(bus.s_cyc_o), 64'h0);
        checkOutput("rst_sstb", 64'(bus.s_stb_o), 64'h0);
        checkOutput("rst_ack", 64'(bus.m_ack_o), 64'h0);
        checkOutput("rst_err", 64'(bus.m_err_o), 64'h0);
        tick();
        rst_n = 1'b1;

        // Test 1: M0 read from uart, ack on second strobe cycle
        tick();
        adr = 32'h2000_0004;
        slv = decodeSlave(adr);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, adr, 32'h0);
        #1;
        checkOutput("t1_arb_latency_stb", 64'(bus.s_stb_o), 64'h0);
        tick();
        #1;
        checkOutput("t1_gnt", 64'(gnt), 64'(1 << pickGrant(2'b01)));
        checkOutput("t1_stb", 64'(bus.s_stb_o), 64'(1 << slv));
        checkOutput("t1_adr", 64'(bus.s_adr_o[32*slv +: 32]), 64'(adr));
        checkOutput("t1_noack", 64'(bus.m_ack_o), 64'h0);
        tick();
        rdata = $urandom();
        bus.s_dat_i[32*slv +: 32] = rdata;
        bus.s_ack_i[slv] = 1'b1;
        #1;
        checkOutput("t1_ack", 64'(bus.m_ack_o), 64'h1);
        checkOutput("t1_data", 64'(bus.m_dat_o), {rdata, rdata});
        checkOutput("t1_noerr", 64'(bus.m_err_o), 64'h0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, adr, 32'h0);
        bus.s_ack_i = '0;
        #1;
        checkOutput("t1_cyc_drop", 64'(bus.s_cyc_o), 64'h0);
        tick();
        #1;
        checkOutput("t1_idle", 64'(gnt), 64'h0);

        // Test 2: simultaneous requests alternate after reset
        doReset();
        bus.m_cyc_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            g = pickGrant(bus.m_cyc_i);
            #1;
            checkOutput($sformatf("t2_gnt%0d", i), 64'(gnt), 64'(1 << g));
            bus.m_cyc_i[g] = 1'b0;
            rrPtr = (g + 1) % NM;
            tick();
            #1;
            checkOutput($sformatf("t2_idle%0d", i), 64'(gnt), 64'h0);
            bus.m_cyc_i[g] = 1'b1;
        end
        tick();
        bus.m_cyc_i = 2'b00;
        g = pickGrant(2'b11);
        rrPtr = (g + 1) % NM;
        tick();
        tick();

        // Test 3: M1 unmapped access gets a single registered error
        tick();
        adr = {4'h9, 28'($urandom())};
        applyStimulus(1, 1'b1, 1'b1, 1'b0, adr, 32'h0);
        g = pickGrant(2'b10);
        tick();
        #1;
        checkOutput("t3_gnt", 64'(gnt), 64'(1 << g));
        checkOutput("t3_nostb", 64'(bus.s_stb_o), 64'h0);
        checkOutput("t3_err_early", 64'(bus.m_err_o), 64'h0);
        tick();
        #1;
        checkOutput("t3_err", 64'(bus.m_err_o), 64'b10);
        checkOutput("t3_noack", 64'(bus.m_ack_o), 64'h0);
        tick();
        bus.m_stb_i[1] = 1'b0;
        #1;
        checkOutput("t3_err_once", 64'(bus.m_err_o), 64'h0);
        tick();
        bus.m_cyc_i[1] = 1'b0;
        rrPtr = (g + 1) % NM;
        tick();

        // Test 4: gpio stalls, timeout error on the TMO-th stalled cycle
        tick();
        slv = 3;
        adr = randAddr(slv);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, adr, 32'h0);
        g = pickGrant(2'b01);
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (c == TMO) bus.s_ack_i[slv] = 1'b1;
            #1;
            if (c < TMO) begin
                checkOutput($sformatf("t4_stb_c%0d", c), 64'(bus.s_stb_o), 64'(1 << slv));
                checkOutput($sformatf("t4_noerr_c%0d", c), 64'(bus.m_err_o), 64'h0);
            end else begin
                checkOutput("t4_stb_cut", 64'(bus.s_stb_o), 64'h0);
                checkOutput("t4_err", 64'(bus.m_err_o), 64'(1 << g));
                checkOutput("t4_late_ack_dropped", 64'(bus.m_ack_o), 64'h0);
            end
        end
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, adr, 32'h0);
        bus.s_ack_i = '0;
        rrPtr = (g + 1) % NM;
        tick();
        #1;
        checkOutput("t4_freed", 64'(gnt), 64'h0);

        // Test 5: M0 burst of 4 writes holds the bus while M1 waits
        slv = $urandom_range(NS - 1);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, randAddr(slv), $urandom());
        g = pickGrant(2'b01);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, randAddr(0), 32'h0);
        for (int b = 0; b < 4; b++) begin
            wdata = $urandom();
            adr = randAddr(slv);
            applyStimulus(0, 1'b1, 1'b1, 1'b1, adr, wdata);
            bus.s_ack_i[slv] = 1'b1;
            #1;
            checkOutput($sformatf("t5_gnt_b%0d", b), 64'(gnt), 64'(1 << g));
            checkOutput($sformatf("t5_ack_b%0d", b), 64'(bus.m_ack_o), 64'(1 << g));
            checkOutput($sformatf("t5_wdat_b%0d", b), 64'(bus.s_dat_o[32*slv +: 32]), 64'(wdata));
            checkOutput($sformatf("t5_we_b%0d", b), 64'(bus.s_we_o[slv]), 64'h1);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, adr, 32'h0);
        bus.s_ack_i = '0;
        rrPtr = (g + 1) % NM;
        #1;
        checkOutput("t5_hold_until_release", 64'(gnt), 64'(1 << g));
        tick();
        #1;
        checkOutput("t5_idle", 64'(gnt), 64'h0);
        g = pickGrant(2'b10);
        tick();
        #1;
        checkOutput("t5_m1_gnt", 64'(gnt), 64'(1 << g));

        // Test 6: async reset mid-transfer, then M0 wins after release
        slv = $urandom_range(NS - 1);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, randAddr(slv), 32'h0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, randAddr(slv), 32'h0);
        #3;
        rst_n = 1'b0;
        bus.s_ack_i = '1;
        #1;
        checkOutput("t6_rst_gnt", 64'(gnt), 64'h0);
        checkOutput("t6_rst_scyc", 64'(bus.s_cyc_o), 64'h0);
        checkOutput("t6_rst_sstb", 64'(bus.s_stb_o), 64'h0);
        checkOutput("t6_rst_ack", 64'(bus.m_ack_o), 64'h0);
        checkOutput("t6_rst_err", 64'(bus.m_err_o), 64'h0);
        tick();
        bus.s_ack_i = '0;
        rst_n = 1'b1;
        rrPtr = 0;
        g = pickGrant(2'b11);
        tick();
        #1;
        checkOutput("t6_gnt_after_rst", 64'(gnt), 64'(1 << g));
        checkOutput("t6_stb_after_rst", 64'(bus.s_stb_o), 64'(1 << slv));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
